// File: rtl/hazard_unit_bp_if.sv
// hazard_unit_bp_if: pipeline-side signal bundle for hazard_unit_bp (master = pipeline, slave = hazard unit)
interface hazard_unit_bp_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] i_pc_id;
  logic [6:0]      i_opcode_id;
  logic [4:0]      i_rs1D, i_rs2D, i_rs1E, i_rs2E;
  logic [4:0]      i_ex_rd, i_mem_rd, i_wb_rd;
  logic            i_ex_regwrite, i_mem_regwrite, i_wb_regwrite;
  logic [1:0]      i_ex_wb_sel;
  logic            i_ex_valid;
  logic [6:0]      i_opcode_ex;
  logic [XLEN-1:0] i_pc_ex;
  logic            i_taken_ex, i_pred_ex;
  logic            o_pred_taken, o_redirect_ex, o_fallthrough_ex;
  logic            stallF, stallD, flushD, flushE, flushMEM;
  logic [1:0]      forward_a, forward_b;
  logic [31:0]     o_perf_mispredict, o_perf_stall;
  modport master (
    output i_pc_id, i_opcode_id, i_rs1D, i_rs2D, i_rs1E, i_rs2E,
           i_ex_rd, i_mem_rd, i_wb_rd, i_ex_regwrite, i_mem_regwrite, i_wb_regwrite,
           i_ex_wb_sel, i_ex_valid, i_opcode_ex, i_pc_ex, i_taken_ex, i_pred_ex,
    input  o_pred_taken, o_redirect_ex, o_fallthrough_ex,
           stallF, stallD, flushD, flushE, flushMEM, forward_a, forward_b,
           o_perf_mispredict, o_perf_stall
  );
  modport slave (
    input  i_pc_id, i_opcode_id, i_rs1D, i_rs2D, i_rs1E, i_rs2E,
           i_ex_rd, i_mem_rd, i_wb_rd, i_ex_regwrite, i_mem_regwrite, i_wb_regwrite,
           i_ex_wb_sel, i_ex_valid, i_opcode_ex, i_pc_ex, i_taken_ex, i_pred_ex,
    output o_pred_taken, o_redirect_ex, o_fallthrough_ex,
           stallF, stallD, flushD, flushE, flushMEM, forward_a, forward_b,
           o_perf_mispredict, o_perf_stall
  );
endinterface

// File: rtl/hazard_unit_bp.sv
// hazard_unit_bp: forwarding, load-use stall FSM and 2-bit BHT predictor; perf counters built only with HAZARD_PERF_CNT_EN
module hazard_unit_bp #(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int LOAD_LAT  = 1
) (
  input logic             i_clk,
  input logic             i_reset,
  hazard_unit_bp_if.slave bus
);
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t               state, state_nx;
  logic [2:0]           cnt, cnt_nx;
  logic [1:0]           bht [2**BHT_IDX_W];
  logic [BHT_IDX_W-1:0] idx_id, idx_ex;
  logic                 br_ex, mispredict, load_use, stall, stall_d, pred, pred_id;
  if (XLEN < BHT_IDX_W + 2) begin : g_bad_cfg
    $error("XLEN too narrow for BHT index");
  end
  assign idx_id = bus.i_pc_id[BHT_IDX_W+1:2];
  assign idx_ex = bus.i_pc_ex[BHT_IDX_W+1:2];
  assign bus.forward_a = (bus.i_mem_regwrite && bus.i_mem_rd != 5'd0 && bus.i_mem_rd == bus.i_rs1E) ? 2'b10 :
                         (bus.i_wb_regwrite && bus.i_wb_rd != 5'd0 && bus.i_wb_rd == bus.i_rs1E) ? 2'b01 : 2'b00;
  assign bus.forward_b = (bus.i_mem_regwrite && bus.i_mem_rd != 5'd0 && bus.i_mem_rd == bus.i_rs2E) ? 2'b10 :
                         (bus.i_wb_regwrite && bus.i_wb_rd != 5'd0 && bus.i_wb_rd == bus.i_rs2E) ? 2'b01 : 2'b00;
  assign br_ex      = bus.i_opcode_ex == OP_B;
  assign mispredict = bus.i_ex_valid && ((br_ex && bus.i_taken_ex != bus.i_pred_ex) ||
                      ((bus.i_opcode_ex == OP_JAL || bus.i_opcode_ex == OP_JALR) && bus.i_taken_ex));
  assign load_use   = bus.i_ex_wb_sel == 2'b00 && bus.i_ex_regwrite && bus.i_ex_rd != 5'd0 &&
                      (bus.i_ex_rd == bus.i_rs1D || bus.i_ex_rd == bus.i_rs2D);
  assign pred       = bus.i_opcode_id == OP_B && bht[idx_id][1];
  assign stall_d    = stall && !mispredict;
  assign pred_id    = pred && !stall_d && !mispredict;
  assign bus.o_pred_taken     = pred;
  assign bus.o_redirect_ex    = mispredict;
  assign bus.o_fallthrough_ex = mispredict && br_ex && bus.i_pred_ex && !bus.i_taken_ex;
  assign bus.stallF   = stall_d;
  assign bus.stallD   = stall_d;
  assign bus.flushD   = mispredict || pred_id;
  assign bus.flushE   = mispredict || stall;
  assign bus.flushMEM = 1'b0;
  // Stall FSM next state: first load-use cycle stalls from IDLE, HOLD covers the remaining LOAD_LAT-1 bubbles
  always_comb begin
    stall    = state == HOLD || load_use;
    state_nx = mispredict ? IDLE :
               state == HOLD ? (cnt == 3'd1 ? IDLE : HOLD) :
               (load_use && LOAD_LAT > 1) ? HOLD : IDLE;
    cnt_nx   = mispredict ? 3'd0 :
               state == HOLD ? cnt - 3'd1 :
               (load_use && LOAD_LAT > 1) ? 3'(LOAD_LAT - 1) : 3'd0;
  end
  // Stall FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // BHT training on resolved B-type branches; reads in the same cycle see the pre-update value
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
    end else if (bus.i_ex_valid && br_ex) begin
      bht[idx_ex] <= bus.i_taken_ex ? (bht[idx_ex] == 2'b11 ? 2'b11 : bht[idx_ex] + 2'b01)
                                    : (bht[idx_ex] == 2'b00 ? 2'b00 : bht[idx_ex] - 2'b01);
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_mis, perf_stall;
  // Free-running event counters, wrapping modulo 2^32
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      perf_mis   <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      perf_mis   <= perf_mis + {31'd0, mispredict};
      perf_stall <= perf_stall + {31'd0, stall_d};
    end
  end
  assign bus.o_perf_mispredict = perf_mis;
  assign bus.o_perf_stall      = perf_stall;
`else
  assign bus.o_perf_mispredict = 32'd0;
  assign bus.o_perf_stall      = 32'd0;
`endif
endmodule
